// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder over a valid/ready request handshake.
// Optional ALIGN_CHECK_EN: misaligned byte addresses fault instead of accessing.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [29:0] idx;
    logic [AW-1:0] mem_idx;
    logic        in_range;
    logic        misalign;
    logic        err;
    logic        enter_resp;

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;

    // With LATENCY==1 the access happens on the accept edge itself,
    // so the live request must feed the datapath, not the latches.
    always_comb begin
        sel_write = lat_write;
        sel_addr  = lat_addr;
        sel_wdata = lat_wdata;
        if (state == IDLE) begin
            sel_write = req_write;
            sel_addr  = req_addr;
            sel_wdata = req_wdata;
        end
        idx      = sel_addr[31:2];
        mem_idx  = idx[AW-1:0];
        in_range = (idx < 30'(DEPTH_WORDS));
        err      = ~in_range | misalign;
        enter_resp = 1'b0;
        if (state == IDLE && req_valid && LATENCY == 1)
            enter_resp = 1'b1;
        if (state == WAIT && cnt == 4'd1)
            enter_resp = 1'b1;
    end

`ifdef ALIGN_CHECK_EN
    assign misalign = (sel_addr[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign misalign   = 1'b0;
    assign unused_lsb = ^sel_addr[1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            resp_valid <= enter_resp;
            if (enter_resp) begin
                resp_err   <= err;
                resp_rdata <= (err || sel_write) ? 32'd0 : mem[mem_idx];
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && sel_write && !err)
            mem[mem_idx] <= sel_wdata;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
// Second instance with LATENCY=3 exercises continuous back-to-back requests.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        t_valid, t_write;
    logic [31:0] t_addr, t_wdata;
    logic        t_ready, t_rv, t_err, t_busy;
    logic [31:0] t_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(t_valid), .req_ready(t_ready),
        .req_write(t_write), .req_addr(t_addr),
        .req_wdata(t_wdata), .resp_valid(t_rv),
        .resp_rdata(t_rdata), .resp_err(t_err),
        .busy(t_busy)
    );

    // Drives one request, scrambles req_* after accept, returns what came back.
    task automatic do_req(
        input  logic        w,
        input  logic [31:0] a,
        input  logic [31:0] d,
        output logic [31:0] rd,
        output logic        er,
        output int          lat,
        output logic        post_rv,
        output logic        post_rdy,
        output int          rdy_bad
    );
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 32'h0000_0004;
        req_wdata = $urandom;
        lat = 0;
        rdy_bad = 0;
        rd = 'x;
        er = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            if (req_ready || !busy) rdy_bad++;
            if (resp_valid) begin
                lat = k;
                rd = resp_rdata;
                er = resp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        post_rv  = resp_valid;
        post_rdy = req_ready;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        t_valid = 1'b0; t_write = 1'b0;
        t_addr = 32'd0; t_wdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got rv=%b err=%b want 0 0",
                     resp_valid, resp_err);
        end
        checks++;
        if (resp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_rdata got %h want 0", resp_rdata);
        end
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got rdy=%b busy=%b want 1 0",
                     req_ready, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got rdy=%b rv=%b want 1 0",
                     req_ready, resp_valid);
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd;
        logic er, prv, prdy;
        int lat, bad;
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat, prv, prdy, bad);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
            failures++;
            $display("FAIL store_resp got lat=%0d err=%b rd=%h want 2 0 0",
                     lat, er, rd);
        end
        checks++;
        if (prv !== 1'b0 || prdy !== 1'b1 || bad != 0) begin
            failures++;
            $display("FAIL store_pulse got post_rv=%b post_rdy=%b bad=%0d want 0 1 0",
                     prv, prdy, bad);
        end
        do_req(1'b0, 32'h10, 32'h0, rd, er, lat, prv, prdy, bad);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL load_resp got lat=%0d err=%b rd=%h want 2 0 deadbeef",
                     lat, er, rd);
        end
        @(negedge clk);
        checks++;
        if (resp_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL rdata_hold got %h want deadbeef", resp_rdata);
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_rv got %b want 0", resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_out got rv=%b rd=%h err=%b want 0 0 0",
                     resp_valid, resp_rdata, resp_err);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_after got rdy=%b rv=%b want 1 0",
                     req_ready, resp_valid);
        end
    endtask

    task automatic test_back_to_back;
        int accepts = 0;
        @(negedge clk);
        t_valid = 1'b1; t_write = 1'b0; t_addr = 32'h0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (t_ready !== (i % 4 == 0) || t_rv !== (i % 4 == 3)) begin
                failures++;
                $display("FAIL b2b_cycle%0d got rdy=%b rv=%b want %b %b",
                         i, t_ready, t_rv, (i % 4 == 0), (i % 4 == 3));
            end
            if (t_ready) accepts++;
            @(negedge clk);
        end
        t_valid = 1'b0;
        checks++;
        if (accepts != 3) begin
            failures++;
            $display("FAIL b2b_accepts got %0d want 3", accepts);
        end
    endtask

    task automatic test_range;
        logic [31:0] rd;
        logic er, prv, prdy;
        int lat, bad;
        do_req(1'b1, 32'h0, 32'h1111_1111, rd, er, lat, prv, prdy, bad);
        do_req(1'b0, 32'h400, 32'h0, rd, er, lat, prv, prdy, bad);
        checks++;
        if (lat !== 2 || er !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL oob_load got lat=%0d err=%b rd=%h want 2 1 0",
                     lat, er, rd);
        end
        do_req(1'b1, 32'h400, 32'hFFFF_FFFF, rd, er, lat, prv, prdy, bad);
        checks++;
        if (er !== 1'b1) begin
            failures++;
            $display("FAIL oob_store_err got %b want 1", er);
        end
        do_req(1'b0, 32'h0, 32'h0, rd, er, lat, prv, prdy, bad);
        checks++;
        if (er !== 1'b0 || rd !== 32'h1111_1111) begin
            failures++;
            $display("FAIL oob_word0 got err=%b rd=%h want 0 11111111", er, rd);
        end
        do_req(1'b1, 32'h3FC, 32'h0000_5A5A, rd, er, lat, prv, prdy, bad);
        do_req(1'b0, 32'h3FC, 32'h0, rd, er, lat, prv, prdy, bad);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0000_5A5A) begin
            failures++;
            $display("FAIL last_word got err=%b rd=%h want 0 00005a5a", er, rd);
        end
    endtask

    task automatic test_reset_store;
        logic [31:0] rd;
        logic er, prv, prdy;
        int lat, bad;
        int seen = 0;
        do_req(1'b1, 32'h20, 32'hA5A5_A5A5, rd, er, lat, prv, prdy, bad);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_store_rv got %0d pulses want 0", seen);
        end
        do_req(1'b0, 32'h20, 32'h0, rd, er, lat, prv, prdy, bad);
        checks++;
        if (er !== 1'b0 || rd !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL rst_store_old got err=%b rd=%h want 0 a5a5a5a5", er, rd);
        end
    endtask

    task automatic test_align;
        logic [31:0] rd;
        logic er, prv, prdy;
        int lat, bad;
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef ALIGN_CHECK_EN
        exp_err  = 1'b1;
        exp_word = 32'hA5A5_A5A5;
`else
        exp_err  = 1'b0;
        exp_word = 32'hCAFE_0001;
`endif
        do_req(1'b1, 32'h22, 32'hCAFE_0001, rd, er, lat, prv, prdy, bad);
        checks++;
        if (lat !== 2 || er !== exp_err) begin
            failures++;
            $display("FAIL align_store got lat=%0d err=%b want 2 %b",
                     lat, er, exp_err);
        end
        do_req(1'b0, 32'h20, 32'h0, rd, er, lat, prv, prdy, bad);
        checks++;
        if (er !== 1'b0 || rd !== exp_word) begin
            failures++;
            $display("FAIL align_word8 got err=%b rd=%h want 0 %h", er, rd, exp_word);
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_reset_midstream;
        test_back_to_back;
        test_range;
        test_reset_store;
        test_align;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
